// File: rtl/down_timer_sched_if.sv
// Request/grant/countdown bundle between the timer scheduler and its two clients.
interface down_timer_sched_if #(
    parameter int unsigned WIDTH = 3
);
    logic             t;
    logic             req0;
    logic [WIDTH-1:0] len0;
    logic             req1;
    logic [WIDTH-1:0] len1;
    logic             gnt0;
    logic             gnt1;
    logic             done0;
    logic             done1;
    logic             busy;
    logic [WIDTH-1:0] q;

    // Client side: raises requests and ticks, observes grants/completions.
    modport master (
        output t, req0, len0, req1, len1,
        input  gnt0, gnt1, done0, done1, busy, q
    );

    // Scheduler side.
    modport slave (
        input  t, req0, len0, req1, len1,
        output gnt0, gnt1, done0, done1, busy, q
    );
endinterface

// File: rtl/down_timer_sched.sv
// Round-robin scheduler sharing one down-counter between two requesters.
// A grant loads the counter with the winner's length; the counter then
// decrements on enabled ticks and a one-cycle DONE goes back to the owner
// on the edge after it reaches zero.
module down_timer_sched #(
    parameter int unsigned WIDTH = 3
) (
    input  logic                clk,
    input  logic                rst,
    down_timer_sched_if.slave   bus
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic             done0_q, done0_d;
    logic             done1_q, done1_d;
    logic             busy_q, busy_d;
    logic             win1;

    // State and registered outputs; last-served resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            q_q     <= '0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            busy_q  <= busy_d;
        end
    end

    // Arbitration, counter update and next-state; pulses default low every cycle.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        owner_d = owner_q;
        last_d  = last_q;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        done0_d = 1'b0;
        done1_d = 1'b0;
        busy_d  = busy_q;
        win1    = 1'b0;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (bus.req0 || bus.req1) begin
                    // On a tie the requester that was not served last wins.
                    win1    = bus.req1 && (!bus.req0 || (last_q == 1'b0));
                    q_d     = win1 ? bus.len1 : bus.len0;
                    owner_d = win1;
                    last_d  = win1;
                    gnt0_d  = !win1;
                    gnt1_d  = win1;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy_d = 1'b1;
                if (q_q == '0) begin
                    // Completion does not wait for a tick.
                    done0_d = !owner_q;
                    done1_d = owner_q;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (bus.t) begin
                    q_d = q_q - WIDTH'(1);
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Drive the registered outputs onto the bundle.
    assign bus.q     = q_q;
    assign bus.gnt0  = gnt0_q;
    assign bus.gnt1  = gnt1_q;
    assign bus.done0 = done0_q;
    assign bus.done1 = done1_q;
    assign bus.busy  = busy_q;

endmodule
